i2s_tx_scheduler: RTL and testbench
===================================

Name: i2s_tx_scheduler

Overview:
Transmit-side frame scheduler for the audio clock generator. It takes the generator's free-running decrementing 8-bit phase count (256 mclk per stereo frame, 64 bclk, wclk = count bit 7) and accepts stereo sample pairs over a valid/ready handshake into a 2-entry buffer. At each frame boundary it loads one pair and serialises it I2S-style (MSB first, one-bclk delay after the wclk edge), timed so sdata changes on bclk falling edges. It also handles start/stop sequencing and underrun.

Parameters:
DATA_W, 24, sample width in bits, legal 1..31
UNDERRUN_HOLD, 1, 1 = repeat the last pair on underrun; 0 = send zeros

Ports:
mclk  in  1  master clock, same clock as the clock generator
rst  in  1  asynchronous, active-high reset
en  in  1  transmit enable, level
cnt256_n  in  8  phase count from the clock generator; decrements by 1 every mclk
s_valid  in  1  sample pair valid
s_ready  out  1  buffer can accept a pair
s_left  in  DATA_W  left sample, two's complement
s_right  in  DATA_W  right sample
sdata  out  1  serial data to the codec, registered
frame_start  out  1  one-cycle pulse when a pair is loaded (or an underrun occurs) at a frame boundary
underrun  out  1  one-cycle pulse when a boundary finds the buffer empty in RUN
underrun_cnt  out  8  saturating underrun count; cleared only by rst
running  out  1  high in RUN

Behaviour:
- Reset values: sdata=0, s_ready=1, frame_start=0, underrun=0, underrun_cnt=0, running=0. Buffer is emptied, active pair=0, last pair=0, state=IDLE.
- Let n = cnt256_n − 1 (mod 256), the count after the current edge.
  - Channel is n[7]: 0 = left (wclk low), 1 = right.
  - Slot p = 31 − n[6:2], range 0..31.
- Bit update edge: any posedge where cnt256_n[1:0]==2'b00, so the new bit appears with bclk falling. sdata holds between update edges.
- Bit value at an update edge: if p==0 or p>DATA_W, sdata=0. Otherwise sdata = word[DATA_W−p], where word is the active left or right sample for the channel.
- Frame boundary: the posedge where cnt256_n==8'd128 (n=127, start of left slot p=0). A frame is left then right, 256 mclk.
- Buffer: 2-entry FIFO of {left,right}.
  - s_ready = !full, registered.
  - A push occurs when s_valid && s_ready.
  - Push and pop in the same cycle: both happen, occupancy unchanged.
  - When full, no push is accepted even if a pop occurs that cycle; s_ready rises the following cycle.
- States:
  - IDLE: sdata=0, no pops. Pushes are still accepted. Go to PRIME when en=1.
  - PRIME: sdata=0. Go to IDLE if en=0. At a boundary with the buffer non-empty: pop into the active pair, pulse frame_start, go to RUN.
  - RUN: at each boundary:
    - en=0: go to IDLE. No pop; sdata is held 0 from that edge on. The buffer is retained.
    - Otherwise, if non-empty: pop into the active pair and last pair; pulse frame_start.
    - Otherwise (empty): pulse underrun and frame_start; underrun_cnt += 1, saturating at 255. Active pair = last pair if UNDERRUN_HOLD else 0.
  - A mid-frame en drop is ignored until the boundary, so the current frame always completes.
- The active pair changes only at boundaries. A push at the boundary edge itself is not visible to that edge's pop.
- cnt256_n is trusted: no discontinuity detection. A jump simply shifts the slot mapping.
- rst mid-frame: all state clears immediately (asynchronous). sdata=0 until the first RUN frame.

Test Plan:
- Reset then en=1, push L=24'h800001, R=24'h7FFFFE before the first boundary; capture sdata at bclk rising edges.
  - Required: first boundary at cnt256_n==128 gives frame_start=1 and running=1.
  - Left slot: p0=0, bits p1..p24 = 1000…0001, p25..p31=0.
  - Right slot: 0, then 0111…1110.
- Push 2 pairs with no s_valid drop, hold s_valid with a 3rd pair.
  - s_ready=0 after the 2nd push. 3rd accepted the cycle after the next boundary pop; no pair lost or duplicated over 3 frames.
- Push one pair, run 3 frames with UNDERRUN_HOLD=1.
  - Frames 2 and 3 repeat the pair; underrun pulses twice; underrun_cnt=2.
  - With UNDERRUN_HOLD=0, frames 2 and 3 are all zeros.
- Drop en at cnt256_n==200 during RUN.
  - The current frame completes. At the next cnt256_n==128 edge: running=0, sdata=0 thereafter, buffer occupancy unchanged.
- Assert rst asynchronously between clock edges mid-right-slot.
  - All outputs go to reset values immediately. After release with en=1 and a pair pushed, transmission restarts only at the next boundary.
- Force 300 consecutive underrun boundaries: underrun_cnt saturates at 255 and does not wrap.

Source files
------------

// File: rtl/i2s_tx_scheduler.sv
// i2s_tx_scheduler
//
// Transmit-side I2S frame scheduler. Follows the clock generator's
// decrementing 8-bit phase count (256 mclk per stereo frame, 4 mclk per
// bclk). Stereo sample pairs are taken through a valid/ready handshake into a
// 2-entry buffer. At each frame boundary one pair is loaded and serialised
// MSB first with the I2S one-bclk delay. sdata updates on the mclk edges that
// coincide with bclk falling. The block also sequences start/stop and
// handles underrun.
//
// Ports:
//   mclk          master clock, shared with the clock generator
//   rst           asynchronous active-high reset
//   en            transmit enable (level)
//   cnt256_n      generator phase count, decrements every mclk
//   s_valid       sample pair valid
//   s_ready       buffer can accept a pair (registered, = !full)
//   s_left        left sample, two's complement
//   s_right       right sample, two's complement
//   sdata         registered serial data to the codec
//   frame_start   one-cycle pulse when a pair (or underrun fill) is loaded
//   underrun      one-cycle pulse when a RUN boundary finds the buffer empty
//   underrun_cnt  saturating underrun count, cleared only by rst
//   running       high while in RUN
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | sdata held 0, buffer still accepts pushes, wait for en
// S_PRIME | enabled, wait for a boundary with data in the buffer
// S_RUN   | transmitting; reload (or underrun) at every boundary

module i2s_tx_scheduler #(
    parameter int DATA_W        = 24,
    parameter int UNDERRUN_HOLD = 1
) (
    input  logic              mclk,
    input  logic              rst,
    input  logic              en,
    input  logic [7:0]        cnt256_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              sdata,
    output logic              frame_start,
    output logic              underrun,
    output logic [7:0]        underrun_cnt,
    output logic              running
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Phase after the current edge; all slot decoding is done on this value.
    logic [7:0] cnt_next;
    logic       bit_edge;
    logic       boundary;

    assign cnt_next = cnt256_n - 8'd1;
    assign bit_edge = (cnt256_n[1:0] == 2'b00);
    assign boundary = (cnt_next == 8'd127);

    // Buffer
    logic [2*DATA_W-1:0] fifo_mem [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          fill;
    logic [1:0]          fill_nxt;
    logic                push;
    logic                pop;
    logic                starve;

    // Active and last-transmitted pairs
    logic [DATA_W-1:0] act_l;
    logic [DATA_W-1:0] act_r;
    logic [DATA_W-1:0] last_l;
    logic [DATA_W-1:0] last_r;

    logic [DATA_W-1:0] word;
    logic [31:0]       slot_vec;
    logic              slot_bit;

    assign running = (state == S_RUN);
    assign push    = s_valid && s_ready;

    // FSM state register
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and boundary actions
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        starve    = 1'b0;
        case (state)
            S_IDLE: begin
                if (en) begin
                    state_nxt = S_PRIME;
                end
            end
            S_PRIME: begin
                if (!en) begin
                    state_nxt = S_IDLE;
                end else if (boundary && (fill != 2'd0)) begin
                    pop       = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // en is only sampled at the boundary so a frame always completes
                if (boundary) begin
                    if (!en) begin
                        state_nxt = S_IDLE;
                    end else if (fill != 2'd0) begin
                        pop = 1'b1;
                    end else begin
                        starve = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        fill_nxt = fill;
        if (push && !pop) begin
            fill_nxt = fill + 2'd1;
        end else if (pop && !push) begin
            fill_nxt = fill - 2'd1;
        end
    end

    // Pointers and occupancy; s_ready is the registered !full so a pop
    // while full frees a slot only from the next cycle on.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            fill    <= 2'd0;
            s_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
            fill    <= fill_nxt;
            s_ready <= (fill_nxt != 2'd2);
        end
    end

    always_ff @(posedge mclk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {s_left, s_right};
        end
    end

    // Left-justify the sample in a 32-slot word: slot p lands on bit 31-p,
    // which is exactly cnt_next[6:2]. Slot 0 and slots past DATA_W read 0.
    assign word     = cnt_next[7] ? act_r : act_l;
    assign slot_vec = 32'(word) << (31 - DATA_W);
    assign slot_bit = slot_vec[cnt_next[6:2]];

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            act_l        <= '0;
            act_r        <= '0;
            last_l       <= '0;
            last_r       <= '0;
            sdata        <= 1'b0;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= 8'd0;
        end else begin
            frame_start <= pop || starve;
            underrun    <= starve;
            if (pop) begin
                {act_l, act_r}   <= fifo_mem[rd_ptr];
                {last_l, last_r} <= fifo_mem[rd_ptr];
            end else if (starve) begin
                if (UNDERRUN_HOLD != 0) begin
                    act_l <= last_l;
                    act_r <= last_r;
                end else begin
                    act_l <= '0;
                    act_r <= '0;
                end
                if (underrun_cnt != 8'hFF) begin
                    underrun_cnt <= underrun_cnt + 8'd1;
                end
            end
            // Boundary edge is slot 0, so the reload above never races the bit.
            if (bit_edge) begin
                sdata <= (state == S_RUN) && slot_bit;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// Testbench for i2s_tx_scheduler: two instances (hold and zero underrun fill)
// share all inputs and are compared every cycle against a queue-based
// reference model, plus directed frame captures.

module tb_i2s_tx_scheduler;

    localparam int DW      = 24;
    localparam int M_IDLE  = 0;
    localparam int M_PRIME = 1;
    localparam int M_RUN   = 2;

    typedef struct packed {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } pair_t;

    logic          mclk = 1'b0;
    logic          rst;
    logic          en;
    logic [7:0]    cnt256_n;
    logic          s_valid;
    logic [DW-1:0] s_left;
    logic [DW-1:0] s_right;

    logic       ready_h, sdata_h, fs_h, ur_h, run_h;
    logic [7:0] ucnt_h;
    logic       ready_z, sdata_z, fs_z, ur_z, run_z;
    logic [7:0] ucnt_z;

    always #5 mclk = ~mclk;

    i2s_tx_scheduler #(.DATA_W(DW), .UNDERRUN_HOLD(1)) dut_hold (
        .mclk(mclk), .rst(rst), .en(en), .cnt256_n(cnt256_n),
        .s_valid(s_valid), .s_ready(ready_h), .s_left(s_left), .s_right(s_right),
        .sdata(sdata_h), .frame_start(fs_h), .underrun(ur_h),
        .underrun_cnt(ucnt_h), .running(run_h)
    );

    i2s_tx_scheduler #(.DATA_W(DW), .UNDERRUN_HOLD(0)) dut_zero (
        .mclk(mclk), .rst(rst), .en(en), .cnt256_n(cnt256_n),
        .s_valid(s_valid), .s_ready(ready_z), .s_left(s_left), .s_right(s_right),
        .sdata(sdata_z), .frame_start(fs_z), .underrun(ur_z),
        .underrun_cnt(ucnt_z), .running(run_z)
    );

    int checks   = 0;
    int failures = 0;

    // reference model state
    pair_t q[$];
    pair_t sent[$];
    int    mode;
    pair_t act_h, act_z, last;
    int    ucnt;
    logic  m_ready, m_fs, m_ur, m_sd_h, m_sd_z, m_acc;
    pair_t m_acc_pair;

    // stimulus control
    logic [7:0]  last_cnt;
    logic        fast;
    logic        rand_on;
    int unsigned rand_pct;
    int          feed_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic tx_bit(input pair_t pr, input int c);
        int n, p;
        logic [DW-1:0] w;
        n = (c + 255) % 256;
        p = 31 - ((n / 4) % 32);
        w = (n >= 128) ? pr.r : pr.l;
        if (p == 0 || p > DW) return 1'b0;
        w = w >> (DW - p);
        return w[0];
    endfunction

    function automatic logic [63:0] frame_of(input pair_t pr);
        return {1'b0, pr.l, 7'd0, 1'b0, pr.r, 7'd0};
    endfunction

    task automatic model_reset();
        q.delete();
        sent.delete();
        mode    = M_IDLE;
        act_h   = '0;
        act_z   = '0;
        last    = '0;
        ucnt    = 0;
        m_ready = 1'b1;
        m_fs    = 1'b0;
        m_ur    = 1'b0;
        m_sd_h  = 1'b0;
        m_sd_z  = 1'b0;
        m_acc   = 1'b0;
    endtask

    task automatic model_edge();
        logic  bnd;
        pair_t pr;
        bnd        = (cnt256_n == 8'd128);
        m_acc      = s_valid && m_ready;
        m_acc_pair = {s_left, s_right};
        m_fs       = 1'b0;
        m_ur       = 1'b0;
        if (cnt256_n[1:0] == 2'b00) begin
            m_sd_h = (mode == M_RUN) && tx_bit(act_h, int'(cnt256_n));
            m_sd_z = (mode == M_RUN) && tx_bit(act_z, int'(cnt256_n));
        end
        if (mode == M_IDLE) begin
            if (en) mode = M_PRIME;
        end else if (mode == M_PRIME) begin
            if (!en) begin
                mode = M_IDLE;
            end else if (bnd && q.size() > 0) begin
                pr    = q.pop_front();
                act_h = pr;
                act_z = pr;
                last  = pr;
                m_fs  = 1'b1;
                mode  = M_RUN;
            end
        end else if (bnd) begin
            if (!en) begin
                mode = M_IDLE;
            end else if (q.size() > 0) begin
                pr    = q.pop_front();
                act_h = pr;
                act_z = pr;
                last  = pr;
                m_fs  = 1'b1;
            end else begin
                m_fs  = 1'b1;
                m_ur  = 1'b1;
                if (ucnt < 255) ucnt++;
                act_h = last;
                act_z = '0;
            end
        end
        if (m_acc) q.push_back(m_acc_pair);
        m_ready = (q.size() < 2);
    endtask

    task automatic compare();
        chk("sdata_hold",   64'(sdata_h), 64'(m_sd_h));
        chk("sdata_zero",   64'(sdata_z), 64'(m_sd_z));
        chk("s_ready_hold", 64'(ready_h), 64'(m_ready));
        chk("s_ready_zero", 64'(ready_z), 64'(m_ready));
        chk("fstart_hold",  64'(fs_h),    64'(m_fs));
        chk("fstart_zero",  64'(fs_z),    64'(m_fs));
        chk("urun_hold",    64'(ur_h),    64'(m_ur));
        chk("urun_zero",    64'(ur_z),    64'(m_ur));
        chk("ucnt_hold",    64'(ucnt_h),  64'(ucnt));
        chk("ucnt_zero",    64'(ucnt_z),  64'(ucnt));
        chk("run_hold",     64'(run_h),   64'(mode == M_RUN));
        chk("run_zero",     64'(run_z),   64'(mode == M_RUN));
    endtask

    task automatic tick();
        if (rst) model_reset();
        else     model_edge();
        @(posedge mclk);
        #1;
        compare();
        last_cnt = cnt256_n;
        if (m_acc) sent.push_back(m_acc_pair);
        if (fast && cnt256_n == 8'd128) cnt256_n = 8'd131;
        else                            cnt256_n = cnt256_n - 8'd1;
        if (rand_on) begin
            if (m_acc || !s_valid) begin
                s_valid = ($urandom_range(99) < rand_pct);
                s_left  = DW'($urandom);
                s_right = DW'($urandom);
            end
            if ($urandom_range(999) == 0) en = !en;
        end else if (m_acc && feed_cnt > 0) begin
            feed_cnt--;
            if (feed_cnt > 0) begin
                s_left  = DW'($urandom);
                s_right = DW'($urandom);
            end else begin
                s_valid = 1'b0;
            end
        end
    endtask

    task automatic start_feed(input int n);
        feed_cnt = n;
        s_valid  = 1'b1;
        s_left   = DW'($urandom);
        s_right  = DW'($urandom);
    endtask

    task automatic do_reset();
        s_valid  = 1'b0;
        feed_cnt = 0;
        rand_on  = 1'b0;
        fast     = 1'b0;
        en       = 1'b0;
        rst      = 1'b1;
        repeat (3) tick();
        rst      = 1'b0;
        cnt256_n = 8'd250;
    endtask

    // Waits for the next boundary edge, then collects the 64 bit slots of
    // the frame that starts there (first bit = left slot 0).
    task automatic capture_frame(output logic [63:0] ch, output logic [63:0] cz,
                                 output logic fs_b, output logic run_b);
        int guard;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (last_cnt != 8'd128 && guard < 600);
        chk("wait_boundary", 64'(last_cnt), 64'd128);
        fs_b  = fs_h;
        run_b = run_h;
        ch    = {63'd0, sdata_h};
        cz    = {63'd0, sdata_z};
        repeat (255) begin
            tick();
            if (last_cnt[1:0] == 2'b00) begin
                ch = {ch[62:0], sdata_h};
                cz = {cz[62:0], sdata_z};
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ch, cz;
        logic        fs_b, run_b;
        pair_t       dir_pair;
        int          guard;

        rst = 1'b0; en = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0;
        cnt256_n = 8'($urandom);
        fast = 1'b0; rand_on = 1'b0; rand_pct = 0; feed_cnt = 0; last_cnt = 8'd0;
        model_reset();
        #1 rst = 1'b1;
        #2;
        chk("rst_sdata",  64'(sdata_h), 64'd0);
        chk("rst_ready",  64'(ready_h), 64'd1);
        chk("rst_fstart", 64'(fs_h),    64'd0);
        chk("rst_urun",   64'(ur_h),    64'd0);
        chk("rst_ucnt",   64'(ucnt_h),  64'd0);
        chk("rst_run",    64'(run_h),   64'd0);

        // directed pair, one push, three frames (second and third underrun)
        do_reset();
        en = 1'b1;
        start_feed(1);
        s_left   = 24'h800001;
        s_right  = 24'h7FFFFE;
        dir_pair = {s_left, s_right};
        capture_frame(ch, cz, fs_b, run_b);
        chk("first_fstart",  64'(fs_b),  64'd1);
        chk("first_running", 64'(run_b), 64'd1);
        chk("f1_hold", ch, frame_of(dir_pair));
        chk("f1_zero", cz, frame_of(dir_pair));
        capture_frame(ch, cz, fs_b, run_b);
        chk("f2_hold", ch, frame_of(dir_pair));
        chk("f2_zero", cz, 64'd0);
        capture_frame(ch, cz, fs_b, run_b);
        chk("f3_hold", ch, frame_of(dir_pair));
        chk("f3_zero", cz, 64'd0);
        chk("ucnt_two_hold", 64'(ucnt_h), 64'd2);
        chk("ucnt_two_zero", 64'(ucnt_z), 64'd2);

        // back-to-back pushes with a third pair waiting on full
        do_reset();
        en = 1'b1;
        start_feed(3);
        guard = 0;
        while (sent.size() < 2 && guard < 50) begin
            tick();
            guard++;
        end
        chk("wait_push2", 64'(sent.size()), 64'd2);
        chk("full_ready", 64'(ready_h), 64'd0);
        for (int k = 0; k < 3; k++) begin
            capture_frame(ch, cz, fs_b, run_b);
            chk("order_frame", ch, (sent.size() > k) ? frame_of(sent[k]) : 64'hDEAD);
        end
        chk("three_sent", 64'(sent.size()), 64'd3);

        // en drop mid-frame with a full buffer, then resume from the buffer
        do_reset();
        en = 1'b1;
        start_feed(4);
        capture_frame(ch, cz, fs_b, run_b);
        chk("c_frame1", ch, frame_of(sent[0]));
        guard = 0;
        while (cnt256_n != 8'd200 && guard < 400) begin
            tick();
            guard++;
        end
        chk("wait_cnt200", 64'(cnt256_n), 64'd200);
        en = 1'b0;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (last_cnt != 8'd128 && guard < 400);
        chk("drop_boundary", 64'(last_cnt), 64'd128);
        chk("drop_running",  64'(run_h),    64'd0);
        chk("drop_ready",    64'(ready_h),  64'd0);
        repeat (300) tick();
        chk("kept_ready",    64'(ready_h),  64'd0);
        en = 1'b1;
        capture_frame(ch, cz, fs_b, run_b);
        chk("resume_fstart", 64'(fs_b), 64'd1);
        chk("resume_frame1", ch, frame_of(sent[2]));
        capture_frame(ch, cz, fs_b, run_b);
        chk("resume_frame2", ch, frame_of(sent[3]));

        // asynchronous reset in the middle of the right slot
        guard = 0;
        while (cnt256_n != 8'd190 && guard < 300) begin
            tick();
            guard++;
        end
        chk("wait_cnt190", 64'(cnt256_n), 64'd190);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("arst_sdata",  64'(sdata_h), 64'd0);
        chk("arst_ready",  64'(ready_h), 64'd1);
        chk("arst_fstart", 64'(fs_h),    64'd0);
        chk("arst_urun",   64'(ur_h),    64'd0);
        chk("arst_ucnt",   64'(ucnt_h),  64'd0);
        chk("arst_run",    64'(run_h),   64'd0);
        repeat (3) tick();
        #2 rst = 1'b0;
        start_feed(1);
        capture_frame(ch, cz, fs_b, run_b);
        chk("restart_fstart", 64'(fs_b), 64'd1);
        chk("restart_frame",  ch, frame_of(sent[0]));

        // many underrun boundaries using a short phase loop around 128
        do_reset();
        en = 1'b1;
        start_feed(1);
        fast = 1'b1;
        repeat (1500) tick();
        fast = 1'b0;
        chk("sat_hold", 64'(ucnt_h), 64'd255);
        chk("sat_zero", 64'(ucnt_z), 64'd255);

        // randomised traffic, enable toggles and phase jumps
        do_reset();
        rand_on = 1'b1;
        for (int seg = 0; seg < 10; seg++) begin
            case (seg % 4)
                0:       rand_pct = 100;
                1:       rand_pct = 40;
                2:       rand_pct = 5;
                default: rand_pct = 70;
            endcase
            en = ($urandom_range(4) != 0);
            if (seg % 3 == 2) cnt256_n = 8'($urandom);
            repeat (1024) tick();
        end
        rand_on = 1'b0;
        s_valid = 1'b0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
